// File: rtl/VX_gpu_pkg.sv
// Shared KMU scheduler types: default geometry, credit-counter width helper,
// opaque task payload and the performance-counter bundle.
package VX_gpu_pkg;

   localparam int KMU_NUM_CORES    = 4;
   localparam int KMU_MAX_INFLIGHT = 2;
   localparam int KMU_TASK_WIDTH   = 64;

   function automatic int inflight_w(input int max_inflight);
      return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
   endfunction

   localparam int INFLIGHT_W = inflight_w(KMU_MAX_INFLIGHT);

   typedef logic [KMU_TASK_WIDTH-1:0] kmu_task_t;

   typedef struct packed {
      logic [31:0] dispatched;
      logic [31:0] stalls;
   } kmu_sched_perf_t;

endpackage

// File: rtl/kmu_rr_arbiter.sv
// Round-robin arbiter: scans requests starting one past the last accepted
// grant; the pointer only moves when the grant is actually taken.
module kmu_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_advance,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grant_idx,
   output logic               o_any
);

   logic [IDX_W-1:0] r_last_grant;
   logic [IDX_W-1:0] w_cand;
   logic             w_found;
   int               w_pos;

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      w_found     = 1'b0;
      w_pos       = 0;
      w_cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_pos = int'(r_last_grant) + 1 + k;
         if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
         w_cand = IDX_W'(w_pos);
         if (!w_found && i_req[w_cand]) begin
            w_found         = 1'b1;
            o_grant[w_cand] = 1'b1;
            o_grant_idx     = w_cand;
         end
      end
   end

   assign o_any = w_found;

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_last_grant <= IDX_W'(NUM_REQ - 1);
      end else if (i_advance && w_found) begin
         r_last_grant <= o_grant_idx;
      end
   end

endmodule

// File: rtl/kmu_task_sched.sv
// Credit-based round-robin task scheduler with a registered output stage and
// drain/flush sequencing. Define KMU_SCHED_PERF_EN to add perf counters.
module kmu_task_sched
   import VX_gpu_pkg::*;
#(
   parameter int NUM_CORES    = KMU_NUM_CORES,
   parameter int MAX_INFLIGHT = KMU_MAX_INFLIGHT,
   parameter int TASK_WIDTH   = KMU_TASK_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_task_valid,
   input  logic [TASK_WIDTH-1:0] i_task_data,
   output logic                  o_task_ready,
   output logic [NUM_CORES-1:0]  o_core_valid,
   output logic [TASK_WIDTH-1:0] o_core_data,
   input  logic [NUM_CORES-1:0]  i_core_ready,
   input  logic [NUM_CORES-1:0]  i_core_done,
   input  logic                  i_flush_req,
   output logic                  o_flush_done,
   output logic                  o_busy,
   output logic                  o_err
`ifdef KMU_SCHED_PERF_EN
   ,
   output logic [31:0]           o_perf_dispatched,
   output logic [31:0]           o_perf_stalls
`endif
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int CNT_W = inflight_w(MAX_INFLIGHT);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   logic                  r_stage_valid;
   logic [IDX_W-1:0]      r_stage_idx;
   logic [TASK_WIDTH-1:0] r_stage_data;
   logic [CNT_W-1:0]      r_inflight      [NUM_CORES];
   logic [CNT_W-1:0]      w_inflight_next [NUM_CORES];
   logic [1:0]            r_state;
   logic [1:0]            w_state_next;
   logic                  r_err;

   logic [NUM_CORES-1:0]  w_elig;
   logic [NUM_CORES-1:0]  w_grant;
   logic [NUM_CORES-1:0]  w_inc;
   logic [NUM_CORES-1:0]  w_dec;
   logic [NUM_CORES-1:0]  w_busy_core;
   logic [NUM_CORES-1:0]  w_next_busy;
   logic [IDX_W-1:0]      w_grant_idx;
   logic                  w_any_elig;
   logic                  w_consume;
   logic                  w_accept;
   logic                  w_stage_valid_next;
   logic                  w_drained;

   // Credits are reserved on stage entry, so the counters already cover the staged task.
   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         w_elig[i]      = r_inflight[i] < MAX_CNT;
         w_busy_core[i] = r_inflight[i] != '0;
         w_dec[i]       = i_core_done[i] && w_busy_core[i];
      end
   end

   kmu_rr_arbiter #(
      .NUM_REQ (NUM_CORES),
      .IDX_W   (IDX_W)
   ) u_arbiter (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_req       (w_elig),
      .i_advance   (w_accept),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_any       (w_any_elig)
   );

   assign w_consume    = r_stage_valid && i_core_ready[r_stage_idx];
   assign o_task_ready = (r_state == ST_RUN) && !i_flush_req &&
                         (!r_stage_valid || w_consume) && w_any_elig;
   assign w_accept     = i_task_valid && o_task_ready;
   assign w_inc        = w_accept ? w_grant : '0;

   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         w_inflight_next[i] = r_inflight[i];
         if (w_inc[i] && !w_dec[i]) begin
            w_inflight_next[i] = r_inflight[i] + CNT_W'(1);
         end else if (!w_inc[i] && w_dec[i]) begin
            w_inflight_next[i] = r_inflight[i] - CNT_W'(1);
         end
         w_next_busy[i] = w_inflight_next[i] != '0;
      end
   end

   assign w_stage_valid_next = w_accept || (r_stage_valid && !w_consume);
   // Drain completes on post-update state so flush_done follows the last core_done directly.
   assign w_drained = !w_stage_valid_next && (w_next_busy == '0);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN:   if (i_flush_req) w_state_next = ST_DRAIN;
         ST_DRAIN: if (w_drained) w_state_next = ST_DONE;
         ST_DONE:  w_state_next = i_flush_req ? ST_HOLD : ST_RUN;
         default:  if (!i_flush_req) w_state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_stage_valid <= 1'b0;
         r_stage_idx   <= '0;
         r_state       <= ST_RUN;
         r_err         <= 1'b0;
         for (int i = 0; i < NUM_CORES; i++) r_inflight[i] <= '0;
      end else begin
         r_stage_valid <= w_stage_valid_next;
         if (w_accept) r_stage_idx <= w_grant_idx;
         r_state       <= w_state_next;
         r_err         <= r_err || (|(i_core_done & ~w_busy_core));
         for (int i = 0; i < NUM_CORES; i++) r_inflight[i] <= w_inflight_next[i];
      end
   end

   // NOTE: the payload register has no reset; it is only observed while r_stage_valid is set.
   always_ff @(posedge i_clk) begin
      if (w_accept) r_stage_data <= i_task_data;
   end

   always_comb begin
      o_core_valid = '0;
      if (r_stage_valid) o_core_valid[r_stage_idx] = 1'b1;
   end

   assign o_core_data  = r_stage_data;
   assign o_flush_done = (r_state == ST_DONE);
   assign o_busy       = r_stage_valid || (|w_busy_core);
   assign o_err        = r_err;

`ifdef KMU_SCHED_PERF_EN
   kmu_sched_perf_t r_perf;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_perf <= '0;
      end else begin
         if (w_consume) r_perf.dispatched <= r_perf.dispatched + 32'd1;
         if (i_task_valid && !o_task_ready) r_perf.stalls <= r_perf.stalls + 32'd1;
      end
   end

   assign o_perf_dispatched = r_perf.dispatched;
   assign o_perf_stalls     = r_perf.stalls;
`endif

endmodule

// File: tb/tb_kmu_task_sched.sv
// Self-checking bench for kmu_task_sched: directed scenarios plus randomized
// traffic, all compared against a transaction-level model of the scheduler.
module tb_kmu_task_sched;

   localparam int NC = 4;
   localparam int MI = 2;
   localparam int TW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          t_valid;
   logic [TW-1:0] t_data;
   logic          t_ready;
   logic [NC-1:0] c_valid;
   logic [TW-1:0] c_data;
   logic [NC-1:0] c_ready;
   logic [NC-1:0] c_done;
   logic          flush;
   logic          f_done;
   logic          busy;
   logic          err;
`ifdef KMU_SCHED_PERF_EN
   logic [31:0]   perf_disp;
   logic [31:0]   perf_stall;
`endif

   always #5 clk = ~clk;

   kmu_task_sched #(
      .NUM_CORES    (NC),
      .MAX_INFLIGHT (MI),
      .TASK_WIDTH   (TW)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst_n),
      .i_task_valid (t_valid),
      .i_task_data  (t_data),
      .o_task_ready (t_ready),
      .o_core_valid (c_valid),
      .o_core_data  (c_data),
      .i_core_ready (c_ready),
      .i_core_done  (c_done),
      .i_flush_req  (flush),
      .o_flush_done (f_done),
      .o_busy       (busy),
      .o_err        (err)
`ifdef KMU_SCHED_PERF_EN
      ,
      .o_perf_dispatched (perf_disp),
      .o_perf_stalls     (perf_stall)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transaction-level model: credits per core, one pending slot, flush phase.
   typedef enum int {PH_RUN, PH_DRAIN, PH_DONE, PH_HOLD} phase_e;

   int            m_cred [NC];
   int            m_last;
   bit            m_pv;
   int            m_pc;
   logic [TW-1:0] m_pd;
   phase_e        m_phase;
   bit            m_err;
   int unsigned   m_disp;
   int unsigned   m_stall;

   task automatic model_reset();
      for (int k = 0; k < NC; k++) m_cred[k] = 0;
      m_last  = NC - 1;
      m_pv    = 1'b0;
      m_pc    = 0;
      m_pd    = '0;
      m_phase = PH_RUN;
      m_err   = 1'b0;
      m_disp  = 0;
      m_stall = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      t_valid = 1'b0;
      t_data  = '0;
      c_ready = '0;
      c_done  = '0;
      flush   = 1'b0;
      @(negedge clk);
      #1;
      check("rst_ready", t_ready, 1);
      check("rst_core_valid", c_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_flush_done", f_done, 0);
      check("rst_err", err, 0);
      model_reset();
      rst_n = 1'b1;
   endtask

   // One clock cycle: drive inputs, compare outputs to the model, advance the model.
   task automatic step(input bit v, input logic [TW-1:0] d, input logic [NC-1:0] cr,
                       input logic [NC-1:0] cd, input bit fl);
      int            grant;
      bit            found;
      bit            exp_ready;
      bit            exp_busy;
      bit            consume;
      bit            accept;
      bit            all_idle;
      logic [NC-1:0] exp_cv;
      @(negedge clk);
      t_valid = v;
      t_data  = d;
      c_ready = cr;
      c_done  = cd;
      flush   = fl;
      #1;
      found = 1'b0;
      grant = 0;
      for (int k = 0; k < NC; k++) begin
         int c;
         c = (m_last + 1 + k) % NC;
         if (!found && m_cred[c] < MI) begin
            found = 1'b1;
            grant = c;
         end
      end
      exp_ready = (m_phase == PH_RUN) && !fl && (!m_pv || cr[m_pc]) && found;
      exp_cv    = m_pv ? (NC'(1) << m_pc) : '0;
      exp_busy  = m_pv;
      for (int k = 0; k < NC; k++) if (m_cred[k] != 0) exp_busy = 1'b1;

      check("task_ready", t_ready, exp_ready);
      check("core_valid", c_valid, exp_cv);
      if (m_pv) check("core_data", c_data, m_pd);
      check("busy", busy, exp_busy);
      check("flush_done", f_done, m_phase == PH_DONE);
      check("err", err, m_err);
`ifdef KMU_SCHED_PERF_EN
      check("perf_dispatched", perf_disp, m_disp);
      check("perf_stalls", perf_stall, m_stall);
`endif

      consume = m_pv && cr[m_pc];
      accept  = v && exp_ready;
      if (consume) m_disp++;
      if (v && !exp_ready) m_stall++;
      for (int k = 0; k < NC; k++) begin
         if (cd[k]) begin
            if (m_cred[k] == 0) m_err = 1'b1;
            else m_cred[k]--;
         end
         if (accept && grant == k) m_cred[k]++;
      end
      if (accept) begin
         m_pv   = 1'b1;
         m_pc   = grant;
         m_pd   = d;
         m_last = grant;
      end else if (consume) begin
         m_pv = 1'b0;
      end
      all_idle = !m_pv;
      for (int k = 0; k < NC; k++) if (m_cred[k] != 0) all_idle = 1'b0;
      case (m_phase)
         PH_RUN:   if (fl) m_phase = PH_DRAIN;
         PH_DRAIN: if (all_idle) m_phase = PH_DONE;
         PH_DONE:  m_phase = fl ? PH_HOLD : PH_RUN;
         default:  if (!fl) m_phase = PH_RUN;
      endcase
   endtask

   initial begin
      logic [NC-1:0] one_hot;
      logic [NC-1:0] rnd_done;
      int            pulses;
      bit            fl_state;

      one_hot = 1;
      rst_n   = 1'b1;
      t_valid = 1'b0;
      t_data  = '0;
      c_ready = '0;
      c_done  = '0;
      flush   = 1'b0;
      model_reset();

      // Back-to-back dispatch fills every core, then the ninth task stalls.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 64'h1000 + 64'(i), 4'hF, 4'h0, 1'b0);
         if (i > 0) check("rr_order", c_valid, one_hot << ((i - 1) % NC));
      end
      step(1'b1, 64'h1008, 4'hF, 4'h0, 1'b0);
      check("rr_order_last", c_valid, 4'b1000);
      check("ninth_stall", t_ready, 0);
      step(1'b1, 64'h1008, 4'hF, 4'b0100, 1'b0);
      check("ninth_stall_done_cycle", t_ready, 0);
      step(1'b1, 64'h1008, 4'hF, 4'h0, 1'b0);
      check("ninth_release", t_ready, 1);
      step(1'b0, '0, 4'hF, 4'h0, 1'b0);
      check("ninth_to_core2", c_valid, 4'b0100);

      // Backpressure on core 1 holds the stage steady.
      do_reset();
      step(1'b1, 64'hAAAA_0000_0000_000A, 4'hF, 4'h0, 1'b0);
      step(1'b1, 64'hBBBB_0000_0000_000B, 4'b1101, 4'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 64'hCCCC_0000_0000_000C, 4'b1101, 4'h0, 1'b0);
         check("hold_valid", c_valid, 4'b0010);
         check("hold_data", c_data, 64'hBBBB_0000_0000_000B);
         check("hold_ready", t_ready, 0);
      end
      step(1'b1, 64'hCCCC_0000_0000_000C, 4'hF, 4'h0, 1'b0);
      check("hold_release_ready", t_ready, 1);
      step(1'b0, '0, 4'hF, 4'h0, 1'b0);
      check("hold_next_valid", c_valid, 4'b0100);
      check("hold_next_data", c_data, 64'hCCCC_0000_0000_000C);

      // Same-cycle reservation and completion on core 2 leaves its credit unchanged.
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, 64'h2000 + 64'(i), 4'hF, 4'h0, 1'b0);
      step(1'b1, 64'h2006, 4'hF, 4'b0100, 1'b0);
      step(1'b1, 64'h2007, 4'hF, 4'h0, 1'b0);
      step(1'b1, 64'h2008, 4'hF, 4'h0, 1'b0);
      check("same_cycle_credit", t_ready, 1);
      step(1'b1, 64'h2009, 4'hF, 4'h0, 1'b0);
      check("same_cycle_full", t_ready, 0);

      // Completion on an idle core raises a sticky error.
      do_reset();
      step(1'b0, '0, 4'hF, 4'b1000, 1'b0);
      step(1'b0, '0, 4'hF, 4'h0, 1'b0);
      check("err_set", err, 1);
      for (int i = 0; i < 3; i++) step(1'b1, 64'h3000 + 64'(i), 4'hF, 4'h0, 1'b0);
      check("err_sticky", err, 1);

      // Flush with three tasks in flight.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 64'h4000 + 64'(i), 4'hF, 4'h0, 1'b0);
      step(1'b1, 64'h4003, 4'hF, 4'h0, 1'b1);
      check("flush_blocks", t_ready, 0);
      step(1'b1, 64'h4003, 4'hF, 4'b0001, 1'b1);
      step(1'b1, 64'h4003, 4'hF, 4'b0010, 1'b1);
      step(1'b1, 64'h4003, 4'hF, 4'b0100, 1'b1);
      pulses = 0;
      step(1'b1, 64'h4003, 4'hF, 4'h0, 1'b1);
      check("flush_pulse", f_done, 1);
      check("flush_idle", busy, 0);
      pulses += int'(f_done);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 64'h4003, 4'hF, 4'h0, 1'b1);
         pulses += int'(f_done);
      end
      check("flush_pulse_count", pulses, 1);
      step(1'b1, 64'h4003, 4'hF, 4'h0, 1'b0);
      step(1'b1, 64'h4003, 4'hF, 4'h0, 1'b0);
      check("flush_resume", t_ready, 1);

`ifdef KMU_SCHED_PERF_EN
      // Five dispatches and three stall cycles.
      do_reset();
      step(1'b1, 64'h5000, 4'h0, 4'h0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 64'h5001, 4'h0, 4'h0, 1'b0);
      step(1'b1, 64'h5001, 4'hF, 4'h0, 1'b0);
      step(1'b1, 64'h5002, 4'hF, 4'h0, 1'b0);
      step(1'b1, 64'h5003, 4'hF, 4'h0, 1'b0);
      step(1'b1, 64'h5004, 4'hF, 4'h0, 1'b0);
      step(1'b0, '0, 4'hF, 4'h0, 1'b0);
      step(1'b0, '0, 4'hF, 4'h0, 1'b0);
      check("perf_dispatched_5", perf_disp, 5);
      check("perf_stalls_3", perf_stall, 3);
`endif

      // Randomized traffic with occasional flushes and mid-operation resets.
      do_reset();
      fl_state = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         if ($urandom_range(0, 49) == 0) fl_state = !fl_state;
         rnd_done = '0;
         for (int k = 0; k < NC; k++) begin
            if (m_cred[k] > 0 && $urandom_range(0, 3) == 0) rnd_done[k] = 1'b1;
         end
         step($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, NC'($urandom()),
              rnd_done, fl_state);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/kmu_task_sched.md
# kmu_task_sched

Credit-based scheduler that distributes kernel tasks from the KMU front end across the cluster's cores. Accepts one task per cycle from a single valid/ready stream, selects a core round-robin among those with free in-flight credits, and presents the task on that core's task port through a registered output stage. Sits in the cluster between the KMU and the per-core task ports; also provides a drain/flush sequence and a busy indication for cluster status.

## Interface
- NUM_CORES, 4, number of core task ports (1..32)
- MAX_INFLIGHT, 2, tasks outstanding per core before the core is ineligible
- TASK_WIDTH, 64, opaque task payload width
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- task_valid  in  1  incoming task valid
- task_data  in  TASK_WIDTH  incoming task payload
- task_ready  out  1  task accepted when valid&ready
- core_valid  out  NUM_CORES  one-hot per-core task valid
- core_data  out  TASK_WIDTH  payload, shared by all cores
- core_ready  in  NUM_CORES  per-core accept
- core_done  in  NUM_CORES  per-core single-cycle task-completion pulse
- flush_req  in  1  level; request drain of all in-flight tasks
- flush_done  out  1  single-cycle pulse when drain completes
- busy  out  1  any task held or in flight
- err  out  1  sticky: core_done seen on a core with zero credits used

## Operation
- Per-core counter inflight[i], width $clog2(MAX_INFLIGHT+1); core eligible when inflight[i] < MAX_INFLIGHT.
- Output stage: one register (valid, core index, payload). Holds until core_ready[idx] while core_valid[idx]=1.
- task_ready = state==RUN && (stage empty || stage consumed this cycle) && any eligible core (eligibility evaluated including the in-stage task's reserved credit).
- Credit incremented at acceptance into stage (reservation), decremented on core_done[i]. Same-cycle increment and decrement on one core: net unchanged.
- Arbiter: round-robin, priority starts at core (last_grant+1) mod NUM_CORES; last_grant updates only on acceptance.
- core_done on a core with inflight==0: counter stays 0, err set until reset.
- FSM: RUN -> DRAIN when flush_req=1 (task_ready forced 0); DRAIN -> DONE when stage empty and all inflight==0; DONE pulses flush_done for one cycle -> RUN if flush_req=0, else stays in HOLD (no further pulse) until flush_req=0 then RUN.
- busy = stage valid || any inflight != 0.

## Timing
- Reset (reset=0 at clk edge): stage empty, all inflight=0, last_grant=NUM_CORES-1 (first grant core 0), state RUN, err=0. Outputs after reset: task_ready=1 iff task_valid irrelevant (1), core_valid=0, flush_done=0, busy=0, err=0.
- Latency: task accepted cycle N -> core_valid asserted cycle N+1.
- Throughput: one task/cycle while target cores accept immediately (stage refilled on consume cycle).
- core_valid/core_data stable while not accepted; no retraction.
- Reset mid-operation: all in-flight credits discarded; in-stage task dropped.
- flush_req asserted same cycle as a valid task: task not accepted.

## Configuration
- KMU_SCHED_PERF_EN defined: adds outputs perf_dispatched (32b, count of core handshakes) and perf_stalls (32b, cycles task_valid=1 && task_ready=0), both wrap, reset to 0.
- Undefined: ports absent, no counters.

## Structure
- Shared package (VX_gpu_pkg): task payload typedef kmu_task_t, INFLIGHT_W constant, perf struct kmu_sched_perf_t.
- One sub-module: kmu_rr_arbiter (NUM_CORES requests, one-hot grant, index out, advance-on-accept input).

## Test plan
- Reset, 8 back-to-back tasks, all core_ready=1, NUM_CORES=4, MAX_INFLIGHT=2 -> cores 0,1,2,3,0,1,2,3; 9th task stalls (task_ready=0) until any core_done.
- core_ready[1]=0 held -> core_valid[1] and payload stable; task_ready=0 while stage held; release -> next task in following cycle.
- core_done[2] same cycle as dispatch to core 2 at inflight=1 -> inflight stays 1.
- core_done[3] with inflight[3]=0 -> err=1, stays 1 until reset.
- 3 tasks in flight, flush_req=1 -> task_ready=0; after last core_done, flush_done pulses once next cycle, busy=0.
- With KMU_SCHED_PERF_EN: 5 dispatches, 3 stall cycles -> perf_dispatched=5, perf_stalls=3.
